// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
//
// Shared constants and types for the instruction fetch unit and its prefetch
// queue. This is the header that sits alongside instructions.v.
//
// Contents:
//   IF_NOP_INSTR     - NOP encoding driven to decode when the queue is empty
//                      and IF_NOP_FILL_EN is defined.
//   IF_RESET_VECTOR  - default first fetch address after reset.
//   IF_WORD_BYTES    - fetch PC increment per instruction word.
//   fetch_entry_t    - one prefetch queue entry {pc, instr}.
//   word_align()     - clears the byte offset of an address.
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam logic [31:0] IF_NOP_INSTR    = 32'hE320_F000;
   localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] IF_WORD_BYTES   = 32'd4;

   // One buffered instruction together with the address it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Redirect targets may carry a byte offset; fetch is always word based.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instruction_fetch_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Synchronous prefetch FIFO of {pc, instr} entries with a show-ahead head:
// an entry pushed at edge N is visible on head_entry right after edge N.
// Storage is registered; the head is a plain read of the entry addressed by
// the read pointer, so there is no extra bubble between push and visibility.
//
// Parameters:
//   DEPTH      - number of entries; power of two, at least 2.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   push       in   write push_entry at the tail
//   push_entry in   entry to write
//   pop        in   retire the head entry (ignored while empty)
//   flush      in   discard all entries; overrides push and pop
//   count      out  number of valid entries (0..DEPTH)
//   head_valid out  queue not empty
//   head_entry out  oldest entry (show-ahead)
// ---------------------------------------------------------------------------
module fetch_queue
   import instruction_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic          head_valid,
   output fetch_entry_t  head_entry
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   fetch_entry_t  entry_reg [DEPTH];
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;

   logic do_pop;
   logic do_push;
   logic wr_en;

   // A pop on an empty queue is a no-op. A push into a full queue is only
   // accepted if the head leaves in the same cycle; the fetch unit's request
   // rule already guarantees this, the guard just keeps the FIFO self-safe.
   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && ((count_reg != DEPTH_C) || do_pop);
   assign wr_en   = do_push && !flush;

   // Entry storage carries no reset: contents are only observed through
   // head_valid, which is derived from the reset count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         entry_reg[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         // Simultaneous push and pop leaves the count unchanged.
         if (do_push && !do_pop) begin
            count_reg <= count_reg + CNT_ONE;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - CNT_ONE;
         end
      end
   end

   assign count      = count_reg;
   assign head_valid = (count_reg != '0);
   assign head_entry = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Owns the program counter, issues word reads to instruction memory over a
// request/acknowledge handshake and buffers returned words in a prefetch
// queue feeding instruction_decode. Branch redirects flush the queue, discard
// any in-flight return and restart fetch at the target.
//
// Build option:
//   IF_NOP_FILL_EN - when defined, an empty queue presents the NOP encoding on
//                    instr_o and the current fetch PC on instr_pc_o. When not
//                    defined, both read 0 while the queue is empty.
//
// Parameters:
//   DEPTH           - prefetch queue entries; power of two, at least 2.
//   RESET_PC        - first fetch address after reset; word aligned.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   mem_req_o       out  read request, held until acknowledged
//   mem_addr_o      out  word address of the request
//   mem_ack_i       in   memory accepts and returns data this cycle
//   mem_data_i      in   instruction word, valid with mem_ack_i
//   instr_valid_o   out  queue head valid
//   instr_o         out  queue head instruction
//   instr_pc_o      out  address of the queue head instruction
//   instr_ready_i   in   decode consumes the head this cycle
//   branch_valid_i  in   redirect request from execute
//   branch_target_i in   redirect address, bits [1:0] ignored
// ---------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = IF_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   input  logic        branch_valid_i,
   input  logic [31:0] branch_target_i
);

   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   // Handshake, PC and drop state.
   logic        req_reg,  req_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] pc_reg,   pc_next;
   logic        drop_reg, drop_next;

   // Queue interface.
   logic          q_push;
   logic          q_pop;
   logic          q_flush;
   logic [CW-1:0] q_count;
   logic [CW-1:0] count_next;
   logic          q_valid;
   fetch_entry_t  q_head;
   fetch_entry_t  q_push_entry;

   // An acknowledge only means something while a request is outstanding;
   // a stray ack (e.g. left over from before a reset) is ignored.
   logic ack_live;
   assign ack_live = req_reg && mem_ack_i;

   // Redirect wins over both push and pop.
   assign q_flush = branch_valid_i;
   assign q_push  = ack_live && !drop_reg && !branch_valid_i;
   assign q_pop   = q_valid && instr_ready_i && !branch_valid_i;

   assign q_push_entry.pc    = pc_reg;
   assign q_push_entry.instr = mem_data_i;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_fetch_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (q_push),
      .push_entry (q_push_entry),
      .pop        (q_pop),
      .flush      (q_flush),
      .count      (q_count),
      .head_valid (q_valid),
      .head_entry (q_head)
   );

   // Occupancy the queue will have after this edge; the request decision is
   // made against it so that a freshly issued request always has a free slot.
   always_comb begin
      count_next = q_count;
      if (q_flush) begin
         count_next = '0;
      end else if (q_push && !q_pop) begin
         count_next = q_count + CNT_ONE;
      end else if (q_pop && !q_push) begin
         count_next = q_count - CNT_ONE;
      end
   end

   always_comb begin
      pc_next = pc_reg;
      if (branch_valid_i) begin
         pc_next = word_align(branch_target_i);
      end else if (q_push) begin
         // Wraps modulo 2^32.
         pc_next = pc_reg + IF_WORD_BYTES;
      end
   end

   // The drop flag marks the outstanding request as stale: its data must be
   // thrown away when it returns. Any ack consumes the flag; a redirect that
   // arrives while a request is still waiting (re)arms it. An ack in the same
   // cycle as the redirect is simply not pushed, so no flag is needed then.
   always_comb begin
      drop_next = drop_reg;
      if (ack_live) begin
         drop_next = 1'b0;
      end
      if (branch_valid_i && req_reg && !mem_ack_i) begin
         drop_next = 1'b1;
      end
   end

   // Request/address. A pending request holds both outputs stable, even
   // across a redirect. Once it is acknowledged the request drops for one
   // cycle; while idle a new request starts whenever a slot will be free.
   // The address follows the fetch PC whenever no request is pending.
   always_comb begin
      req_next  = req_reg;
      addr_next = addr_reg;
      if (!(req_reg && !mem_ack_i)) begin
         req_next  = !req_reg && (count_next < DEPTH_C);
         addr_next = pc_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_reg  <= 1'b0;
         addr_reg <= RESET_PC;
         pc_reg   <= RESET_PC;
         drop_reg <= 1'b0;
      end else begin
         req_reg  <= req_next;
         addr_reg <= addr_next;
         pc_reg   <= pc_next;
         drop_reg <= drop_next;
      end
   end

   assign mem_req_o     = req_reg;
   assign mem_addr_o    = addr_reg;
   assign instr_valid_o = q_valid;

`ifdef IF_NOP_FILL_EN
   // Decode always sees a harmless instruction, valid or not.
   assign instr_o    = q_valid ? q_head.instr : IF_NOP_INSTR;
   assign instr_pc_o = q_valid ? q_head.pc    : pc_reg;
`else
   assign instr_o    = q_valid ? q_head.instr : 32'h0000_0000;
   assign instr_pc_o = q_valid ? q_head.pc    : 32'h0000_0000;
`endif

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit that owns the program counter, issues word reads to instruction memory over a request/acknowledge handshake, and buffers returned words in a small prefetch queue. It is the producer for `instruction_decode`: it drives `instr_i`/`instr_valid_i` and retires a queue entry each cycle decode accepts one. Branch redirects from execute flush the queue, discard any in-flight return and restart fetch at the target.

## Interface

- `DEPTH`, 4, prefetch queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; word aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `mem_req_o`  out  1  read request; held until acknowledged.
- `mem_addr_o`  out  32  word address of the request; bits [1:0] always 0.
- `mem_ack_i`  in  1  memory accepts and returns data this cycle.
- `mem_data_i`  in  32  instruction word; valid when `mem_ack_i`.
- `instr_valid_o`  out  1  queue head valid.
- `instr_o`  out  32  queue head instruction, to decode `instr_i`.
- `instr_pc_o`  out  32  address of queue head instruction.
- `instr_ready_i`  in  1  decode consumes head this cycle.
- `branch_valid_i`  in  1  redirect request from execute.
- `branch_target_i`  in  32  redirect address; bits [1:0] ignored.

## Operation

- Reset values: `mem_req_o`=0, `mem_addr_o`=`RESET_PC`, `instr_valid_o`=0, `instr_o`=0 (NOP with macro), `instr_pc_o`=0, queue count 0, drop flag 0, fetch PC=`RESET_PC`.
- Request rule: assert `mem_req_o` when no request outstanding and (count + 1) ≤ `DEPTH` after this cycle's pop/push. One outstanding request maximum.
- While `mem_req_o`=1 and `mem_ack_i`=0, `mem_addr_o` and `mem_req_o` hold stable, including across a redirect.
- On ack: drop flag clear → push {fetch PC, `mem_data_i`}, fetch PC += 4 (wraps modulo 2^32 silently); drop flag set → data discarded, drop flag cleared, fetch PC unchanged.
- Pop: `instr_valid_o` && `instr_ready_i`. `instr_ready_i` while empty is ignored.
- Simultaneous push and pop: count unchanged, head advances.
- Redirect (`branch_valid_i`=1): count ← 0, fetch PC ← `{branch_target_i[31:2],2'b00}`; request outstanding without ack this cycle → drop flag ← 1; ack in the same cycle → that word discarded. Redirect overrides push and pop.
- Redirect while drop flag already set: target updated, flag stays set.
- Full queue never overflows: the request rule reserves space for the outstanding word.
- Reset asserted mid-transaction: all state to reset values immediately; a later `mem_ack_i` with no request is ignored.

## Timing

- First `mem_req_o` high in the cycle after the first rising edge following `rst` deassertion.
- Memory ack at edge N → entry visible on `instr_valid_o`/`instr_o` after edge N (zero-bubble show-ahead head, registered storage).
- Back-to-back requests: next request asserted in the cycle after an ack; sustained rate one word per two cycles with single-cycle memory.
- Redirect at edge R, no outstanding request → `mem_req_o` to target after R; outstanding → target request after the dropped ack.
- `instr_valid_o` low from the edge following redirect until first target word lands.

## Configuration

- `IF_NOP_FILL_EN` defined: when queue empty, `instr_o` drives the NOP encoding 32'hE320F000 and `instr_pc_o` holds fetch PC, so decode sees a harmless instruction regardless of `instr_valid_o`.
- Undefined: when empty, `instr_o` and `instr_pc_o` drive 0.

## Structure

- Shared header (alongside `instructions.v`): NOP encoding constant, default reset vector constant.
- One sub-module `fetch_queue`: synchronous FIFO of {pc, instr}, parameter `DEPTH`, with push, pop, flush, count, show-ahead head.
- PC, handshake and drop flag live in `instruction_fetch`.

## Test plan

- Reset release, memory acks every request after one wait cycle, `instr_ready_i`=1 → addresses 0x0,0x4,0x8 issued in order; decode sees matching words with `instr_pc_o` 0x0,0x4,0x8.
- `instr_ready_i`=0 → exactly 4 words queued, `mem_req_o` stays low until a pop; then resumes at 0x10.
- Redirect to 0x103 while request to 0x8 outstanding, ack two cycles later with 0xDEADBEEF → word dropped, next request 0x100, queue empty until its ack.
- Redirect in same cycle as ack and pop → count 0, acked word discarded, next request at target.
- Fetch PC 0xFFFF_FFFC acked → next request 0x0000_0000.
- `rst` pulsed mid-request → `mem_req_o` falls asynchronously; empty `instr_o` reads 0xE320F000 with `IF_NOP_FILL_EN`, 0 without.
